// File: rtl/glyph_row_pipe.sv
// glyph_row_pipe: two-stage request -> merged glyph ROM -> processed row pipeline.
// S1 registers the request and drives the ROM address; S2 registers the
// mirrored/inverted ROM word. Valid/ready on both sides with full backpressure.
module glyph_row_pipe #(
   parameter int unsigned ROW_WIDTH  = 64,
   parameter int unsigned GLYPH_H    = 64,
   parameter int unsigned NUM_GLYPHS = 9,
   parameter int unsigned CODE_W     = 4,
   parameter int unsigned ROW_W      = 6,
   parameter int unsigned ADDR_W     = 10
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [CODE_W-1:0]    req_code,
   input  logic [ROW_W-1:0]     req_row,
   input  logic                 req_mirror,
   input  logic                 req_invert,
   output logic [ADDR_W-1:0]    rom_addr,
   input  logic [ROW_WIDTH-1:0] rom_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ROW_WIDTH-1:0] out_row,
   output logic [CODE_W-1:0]    out_code,
   output logic [ROW_W-1:0]     out_row_idx,
   output logic [7:0]           err_count
);

   localparam logic [7:0] ERR_MAX = 8'hFF;

   logic                 s1_valid;
   logic [CODE_W-1:0]    s1_code;
   logic [ROW_W-1:0]     s1_row;
   logic                 s1_mirror;
   logic                 s1_invert;
   logic                 s1_bad;
   logic                 s2_valid;

   logic                 adv1_c;
   logic                 adv2_c;
   logic                 accept_c;
   logic                 bad_c;
   logic [ADDR_W-1:0]    addr_c;
   logic [ROW_WIDTH-1:0] mir_c;
   logic [ROW_WIDTH-1:0] proc_c;

   // Flow control: a stage advances when its downstream slot is free or draining.
   always_comb begin
      adv2_c    = !s2_valid || out_ready;
      adv1_c    = !s1_valid || adv2_c;
      req_ready = adv1_c && !Reset;
      accept_c  = req_valid && req_ready;
   end

   // Range check and merged address; out-of-range requests never alias another glyph.
   always_comb begin
      bad_c  = (32'(req_code) >= NUM_GLYPHS) || (32'(req_row) >= GLYPH_H);
      addr_c = ADDR_W'(32'(req_code) * GLYPH_H + 32'(req_row));
   end

   // S1: capture the request, register the ROM address and count bad requests.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         s1_valid  <= 1'b0;
         s1_code   <= '0;
         s1_row    <= '0;
         s1_mirror <= 1'b0;
         s1_invert <= 1'b0;
         s1_bad    <= 1'b0;
         rom_addr  <= '0;
         err_count <= '0;
      end else begin
         if (adv1_c) begin
            s1_valid <= req_valid;
         end
         if (accept_c) begin
            s1_code   <= req_code;
            s1_row    <= req_row;
            s1_mirror <= req_mirror;
            s1_invert <= req_invert;
            s1_bad    <= bad_c;
            rom_addr  <= bad_c ? '0 : addr_c;
            if (bad_c && (err_count != ERR_MAX)) begin
               err_count <= err_count + 8'd1;
            end
         end
      end
   end

   // Row processing on the ROM word: mirror first, then invert; bad entries yield zero.
   always_comb begin
      mir_c = rom_data;
      if (s1_mirror) begin
         for (int i = 0; i < int'(ROW_WIDTH); i++) begin
            mir_c[i] = rom_data[int'(ROW_WIDTH) - 1 - i];
         end
      end
      proc_c = s1_invert ? ~mir_c : mir_c;
      if (s1_bad) begin
         proc_c = '0;
      end
   end

   // S2: output register, held stable while the consumer stalls.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         s2_valid    <= 1'b0;
         out_row     <= '0;
         out_code    <= '0;
         out_row_idx <= '0;
      end else begin
         if (adv2_c) begin
            s2_valid <= s1_valid;
         end
         if (s1_valid && adv2_c) begin
            out_row     <= proc_c;
            out_code    <= s1_code;
            out_row_idx <= s1_row;
         end
      end
   end

   assign out_valid = s2_valid;

endmodule
